raster_traversal: RTL

Bounding-box traversal controller for the combinational triangle inside-test rasterizer. It accepts one triangle per valid/ready handshake and latches its vertices. It computes a screen-clamped bounding box, then drives the rasterizer's sample coordinate across the box in row-major order, one pixel per cycle. Pixels the rasterizer reports as inside are emitted as a backpressured fragment stream to the downstream shading/framebuffer stage.

---
 rtl/raster_traversal_if.sv | 37 +++
 rtl/raster_traversal.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/raster_traversal_if.sv
// Triangle-in, rasterizer-probe and fragment-out signal bundle for raster_traversal.
// Slave is the traversal controller; master is the triangle source, rasterizer and fragment sink.
interface raster_traversal_if #(
  parameter int COORD_W = 11
);
  logic                    aTriValid;
  logic                    anOutTriReady;
  logic [1:0][COORD_W-1:0] aPoint1;
  logic [1:0][COORD_W-1:0] aPoint2;
  logic [1:0][COORD_W-1:0] aPoint3;
  logic [1:0][COORD_W-1:0] anOutPoint1;
  logic [1:0][COORD_W-1:0] anOutPoint2;
  logic [1:0][COORD_W-1:0] anOutPoint3;
  logic [COORD_W-1:0]      anOutRastX;
  logic [COORD_W-1:0]      anOutRastY;
  logic                    aRastInside;
  logic                    anOutFragValid;
  logic                    aFragReady;
  logic [COORD_W-1:0]      anOutFragX;
  logic [COORD_W-1:0]      anOutFragY;
  logic                    anOutBusy;
  logic                    anOutDone;

  modport master (
    output aTriValid, aPoint1, aPoint2, aPoint3, aRastInside, aFragReady,
    input  anOutTriReady, anOutPoint1, anOutPoint2, anOutPoint3,
           anOutRastX, anOutRastY, anOutFragValid, anOutFragX, anOutFragY,
           anOutBusy, anOutDone
  );

  modport slave (
    input  aTriValid, aPoint1, aPoint2, aPoint3, aRastInside, aFragReady,
    output anOutTriReady, anOutPoint1, anOutPoint2, anOutPoint3,
           anOutRastX, anOutRastY, anOutFragValid, anOutFragX, anOutFragY,
           anOutBusy, anOutDone
  );
endinterface

// File: rtl/raster_traversal.sv
// Bounding-box scan controller: first fragment 3 cycles after accept, then one pixel/cycle.
// Backpressure: an inside pixel stalls the cursor while the fragment register is full and not ready.
module raster_traversal #(
  parameter int COORD_W  = 11,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic              aClock,
  input  logic              aReset,
  raster_traversal_if.slave io
);
  typedef logic [COORD_W-1:0]      coord_t;
  typedef logic [1:0][COORD_W-1:0] point_t;
  typedef enum logic [2:0] {IDLE, SETUP, SCAN, DRAIN, DONE} state_t;

  localparam coord_t X_LAST = COORD_W'(SCREEN_W - 1);
  localparam coord_t Y_LAST = COORD_W'(SCREEN_H - 1);

  state_t state, next_state;
  point_t pt1, pt2, pt3;
  coord_t min_x, max_x, min_y, max_y;
  coord_t cur_x, cur_y;
  logic   frag_vld;
  coord_t frag_x, frag_y;

  logic   tri_accept, cur_adv, frag_load, frag_free, at_last, box_empty;
  coord_t s_min_x, s_max_x, s_min_y, s_max_y;

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Box of the latched vertices, upper bounds clamped to the screen.
  always_comb begin
    s_min_x   = min3(pt1[0], pt2[0], pt3[0]);
    s_min_y   = min3(pt1[1], pt2[1], pt3[1]);
    s_max_x   = max3(pt1[0], pt2[0], pt3[0]);
    s_max_y   = max3(pt1[1], pt2[1], pt3[1]);
    if (s_max_x > X_LAST) s_max_x = X_LAST;
    if (s_max_y > Y_LAST) s_max_y = Y_LAST;
    box_empty = (s_min_x > X_LAST) || (s_min_y > Y_LAST);
  end

  assign frag_free = !frag_vld || io.aFragReady;
  assign at_last   = (cur_x == max_x) && (cur_y == max_y);

  always_comb begin
    next_state = state;
    tri_accept = 1'b0;
    cur_adv    = 1'b0;
    frag_load  = 1'b0;
    case (state)
      IDLE: begin
        if (io.aTriValid) begin
          tri_accept = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: next_state = box_empty ? DONE : SCAN;
      SCAN: begin
        if (!io.aRastInside || frag_free) begin
          frag_load = io.aRastInside;
          if (at_last) next_state = DRAIN;
          else         cur_adv    = 1'b1;
        end
      end
      DRAIN: if (frag_free) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge aClock) begin
    if (aReset) begin
      state    <= IDLE;
      pt1      <= '0;
      pt2      <= '0;
      pt3      <= '0;
      min_x    <= '0;
      max_x    <= '0;
      min_y    <= '0;
      max_y    <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      frag_vld <= 1'b0;
      frag_x   <= '0;
      frag_y   <= '0;
    end else begin
      state <= next_state;
      if (tri_accept) begin
        pt1 <= io.aPoint1;
        pt2 <= io.aPoint2;
        pt3 <= io.aPoint3;
      end
      if (state == SETUP) begin
        min_x <= s_min_x;
        max_x <= s_max_x;
        min_y <= s_min_y;
        max_y <= s_max_y;
        cur_x <= s_min_x;
        cur_y <= s_min_y;
      end
      if (cur_adv) begin
        if (cur_x < max_x) begin
          cur_x <= cur_x + 1'b1;
        end else begin
          cur_x <= min_x;
          cur_y <= cur_y + 1'b1;
        end
      end
      if (frag_load) begin
        frag_vld <= 1'b1;
        frag_x   <= cur_x;
        frag_y   <= cur_y;
      end else if (io.aFragReady) begin
        frag_vld <= 1'b0;
      end
    end
  end

  assign io.anOutTriReady  = (state == IDLE);
  assign io.anOutBusy      = (state != IDLE);
  assign io.anOutDone      = (state == DONE);
  assign io.anOutPoint1    = pt1;
  assign io.anOutPoint2    = pt2;
  assign io.anOutPoint3    = pt3;
  assign io.anOutRastX     = cur_x;
  assign io.anOutRastY     = cur_y;
  assign io.anOutFragValid = frag_vld;
  assign io.anOutFragX     = frag_x;
  assign io.anOutFragY     = frag_y;
endmodule
